// File: rtl/sec_key_responder.sv
// Access-sequence security responder: unlocks after a programmed address-nibble
// key, then answers reads with LFSR-derived data until a write or idle timeout.
module sec_key_responder #(
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned KEY_LEN     = 4,
  parameter logic [31:0] KEY         = 32'h0000_28A9,
  parameter logic [STATE_W-1:0] FB_MASK = STATE_W'(6'b110000),
  parameter logic [STATE_W-1:0] SEED    = STATE_W'(6'b000001),
  parameter int unsigned DATA_W      = 2,
  parameter logic [DATA_W*STATE_W-1:0] OUT_TAPS = (DATA_W*STATE_W)'({6'b010110, 6'b101001}),
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              strobe,
  input  logic [3:0]        addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  output logic              armed
);

  localparam int unsigned IDX_W = (KEY_LEN < 2) ? 1 : $clog2(KEY_LEN);
  localparam int unsigned TMR_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);

  typedef enum logic {LOCKED = 1'b0, ARMED = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [STATE_W-1:0] lfsr;
  logic [TMR_W-1:0]   timer;
  logic [4:0]         key_base;
  logic [3:0]         key_nib;
  logic               q_rd;
  logic               q_wr;

  assign q_rd     = strobe & sel & rd;
  assign q_wr     = strobe & sel & ~rd;
  assign key_base = {3'(idx), 2'b00};
  assign key_nib  = KEY[key_base +: 4];

  // Key tracking, LFSR stepping and idle timer in one state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKED;
      idx   <= '0;
      lfsr  <= SEED;
      timer <= '0;
    end else begin
      case (state)
        LOCKED: begin
          timer <= '0;
          if (q_rd) begin
            if (addr == key_nib) begin
              if (idx == IDX_LAST) begin
                state <= ARMED;
                idx   <= '0;
                lfsr  <= SEED;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              idx <= (addr == KEY[3:0]) ? IDX_W'(1) : '0;
            end
          end else if (q_wr) begin
            idx <= '0;
          end
        end
        ARMED: begin
          if (q_rd) begin
            lfsr  <= {lfsr[STATE_W-2:0], ^(lfsr & FB_MASK)};
            timer <= '0;
          end else if (q_wr) begin
            state <= LOCKED;
            idx   <= '0;
            timer <= '0;
          end else if ((TIMEOUT_CYC != 0) && (timer == TO_LAST)) begin
            state <= LOCKED;
            idx   <= '0;
            timer <= '0;
          end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= LOCKED;
          idx   <= '0;
        end
      endcase
      // A stuck all-zero LFSR is reseeded regardless of state
      if (lfsr == '0) lfsr <= SEED;
    end
  end

  assign armed   = (state == ARMED);
  assign dout_oe = sel & rd & armed;

  always_comb begin
    dout = '0;
    if (state == ARMED) begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        dout[i] = ^(lfsr & OUT_TAPS[STATE_W*i +: STATE_W]);
      end
    end
  end

endmodule

// File: tb/tb_sec_key_responder.sv
// Bench for sec_key_responder: vector table, timeout/reset sequences, and
// randomized traffic against a behavioural model.
module tb_sec_key_responder;

  logic       clk = 1'b0;
  logic       rst, sel, rd, strobe;
  logic [3:0] addr;
  logic [1:0] dout;
  logic       dout_oe, armed;

  int compared = 0;
  int mismatched = 0;

  sec_key_responder #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .strobe(strobe), .addr(addr),
    .dout(dout), .dout_oe(dout_oe), .armed(armed)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int key_seq[4] = '{9, 10, 8, 2};
  bit m_armed;
  int m_prog;
  int m_lfsr;
  int m_idle;

  function automatic int par(input int v);
    return $countones(v) % 2;
  endfunction

  function automatic int m_dout();
    if (!m_armed) return 0;
    return (par(m_lfsr & 'h16) << 1) | par(m_lfsr & 'h29);
  endfunction

  task automatic model_clk();
    bit qr, qw;
    int nl;
    qr = strobe & sel & rd;
    qw = strobe & sel & ~rd;
    if (rst) begin
      m_armed = 0; m_prog = 0; m_lfsr = 1; m_idle = 0;
      return;
    end
    nl = m_lfsr;
    if (!m_armed) begin
      if (qr) begin
        if (int'(addr) == key_seq[m_prog]) begin
          m_prog++;
          if (m_prog == 4) begin
            m_armed = 1; m_prog = 0; nl = 1; m_idle = 0;
          end
        end else begin
          m_prog = (int'(addr) == key_seq[0]) ? 1 : 0;
        end
      end else if (qw) begin
        m_prog = 0;
      end
    end else begin
      if (qr) begin
        nl = ((m_lfsr * 2) + par(m_lfsr & 'h30)) % 64;
        m_idle = 0;
      end else if (qw) begin
        m_armed = 0; m_prog = 0;
      end else if (m_idle == 7) begin
        m_armed = 0; m_prog = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (m_lfsr == 0) nl = 1;
    m_lfsr = nl;
  endtask

  task automatic drive(input bit r, input bit s, input bit w, input bit st, input int a);
    rst = r; sel = s; rd = w; strobe = st; addr = 4'(a);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd_step(input int a);
    drive(0, 1, 1, 1, a);
    tick();
  endtask

  task automatic arm();
    rd_step(9); rd_step(10); rd_step(8); rd_step(2);
  endtask

  typedef struct {
    bit r, s, w, st;
    int a;
    int e_armed, e_dout, e_oe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit s, input bit w, input bit st, input int a,
                              input int ea, input int ed, input int eo);
    vec_t v;
    v.r = 0; v.s = s; v.w = w; v.st = st; v.a = a;
    v.e_armed = ea; v.e_dout = ed; v.e_oe = eo;
    return v;
  endfunction

  initial begin
    // basic unlock and LFSR walk
    tbl.push_back(mk(1,1,1, 9, 0,0,0)); tbl.push_back(mk(1,1,1,10, 0,0,0));
    tbl.push_back(mk(1,1,1, 8, 0,0,0)); tbl.push_back(mk(1,1,1, 2, 0,0,0));
    tbl.push_back(mk(1,1,0, 0, 1,1,1)); tbl.push_back(mk(1,1,0, 0, 1,1,1));
    tbl.push_back(mk(1,1,1, 0, 1,1,1)); tbl.push_back(mk(1,1,1, 0, 1,2,1));
    tbl.push_back(mk(1,1,1, 0, 1,2,1)); tbl.push_back(mk(1,1,1, 0, 1,1,1));
    tbl.push_back(mk(0,1,0, 0, 1,2,0)); tbl.push_back(mk(1,0,1, 0, 1,2,0));
    tbl.push_back(mk(1,1,0, 0, 0,0,0));
    // mismatch restarts from idx 0
    tbl.push_back(mk(1,1,1, 9, 0,0,0)); tbl.push_back(mk(1,1,1,10, 0,0,0));
    tbl.push_back(mk(1,1,1, 3, 0,0,0)); tbl.push_back(mk(1,1,1, 9, 0,0,0));
    tbl.push_back(mk(1,1,1,10, 0,0,0)); tbl.push_back(mk(1,1,1, 8, 0,0,0));
    tbl.push_back(mk(1,1,1, 2, 0,0,0)); tbl.push_back(mk(1,1,0, 0, 1,1,1));
    tbl.push_back(mk(1,0,1, 0, 1,1,0));
    // repeated 9 restarts at idx 1
    tbl.push_back(mk(1,1,1, 9, 0,0,0)); tbl.push_back(mk(1,1,1, 9, 0,0,0));
    tbl.push_back(mk(1,1,1,10, 0,0,0)); tbl.push_back(mk(1,1,1, 8, 0,0,0));
    tbl.push_back(mk(1,1,1, 2, 0,0,0)); tbl.push_back(mk(1,1,1, 5, 1,1,1));
    tbl.push_back(mk(1,1,0, 0, 1,2,1)); tbl.push_back(mk(1,0,1, 0, 1,2,0));
    // sel low strobes are ignored
    tbl.push_back(mk(0,1,1, 9, 0,0,0)); tbl.push_back(mk(0,1,1,10, 0,0,0));
    tbl.push_back(mk(0,1,1, 8, 0,0,0)); tbl.push_back(mk(0,1,1, 2, 0,0,0));
    tbl.push_back(mk(1,1,0, 0, 0,0,0));
    // interleaved sel low strobes do not break a valid sequence
    tbl.push_back(mk(1,1,1, 9, 0,0,0)); tbl.push_back(mk(0,1,1, 3, 0,0,0));
    tbl.push_back(mk(1,1,1,10, 0,0,0)); tbl.push_back(mk(0,1,1, 7, 0,0,0));
    tbl.push_back(mk(1,1,1, 8, 0,0,0)); tbl.push_back(mk(0,0,1, 0, 0,0,0));
    tbl.push_back(mk(1,1,1, 2, 0,0,0)); tbl.push_back(mk(1,1,0, 0, 1,1,1));
    tbl.push_back(mk(1,0,1, 0, 1,1,0));
    // locked write clears progress
    tbl.push_back(mk(1,1,1, 9, 0,0,0)); tbl.push_back(mk(1,1,1,10, 0,0,0));
    tbl.push_back(mk(1,0,1, 0, 0,0,0)); tbl.push_back(mk(1,1,1, 8, 0,0,0));
    tbl.push_back(mk(1,1,1, 2, 0,0,0)); tbl.push_back(mk(1,1,0, 0, 0,0,0));

    drive(1, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 1, 1, 0, 0);
    check("reset_armed", int'(armed), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_oe", int'(dout_oe), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].w, tbl[i].st, tbl[i].a);
      check($sformatf("vec%0d_armed", i), int'(armed), tbl[i].e_armed);
      check($sformatf("vec%0d_dout", i), int'(dout), tbl[i].e_dout);
      check($sformatf("vec%0d_oe", i), int'(dout_oe), tbl[i].e_oe);
      tick();
    end

    // idle timeout: drops after exactly 8 idle cycles
    arm();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("to_hold%0d", k), int'(armed), 1);
      tick();
    end
    check("to_drop", int'(armed), 0);

    // read at idle cycle 7 restarts the timer
    arm();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) tick();
    rd_step(0);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("to_restart%0d", k), int'(armed), 1);
      tick();
    end
    check("to_restart_drop", int'(armed), 0);

    // read in the expiry cycle wins
    arm();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) tick();
    rd_step(0);
    drive(0, 0, 0, 0, 0);
    check("to_expiry_read", int'(armed), 1);
    drive(0, 1, 0, 1, 0);
    tick();
    check("to_expiry_relock", int'(armed), 0);

    // reset during key step 3 loses the partial key
    rd_step(9); rd_step(10);
    drive(1, 1, 1, 1, 8);
    tick();
    drive(0, 1, 1, 0, 0);
    check("rst_key_armed", int'(armed), 0);
    check("rst_key_oe", int'(dout_oe), 0);
    rd_step(2);
    drive(0, 1, 1, 0, 0);
    check("rst_key_step4_only", int'(armed), 0);

    // reset during ARMED
    arm();
    rd_step(0);
    drive(1, 1, 1, 1, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    check("rst_armed_armed", int'(armed), 0);
    check("rst_armed_dout", int'(dout), 0);
    check("rst_armed_oe", int'(dout_oe), 0);
    arm();
    drive(0, 1, 1, 0, 0);
    check("rst_rearm_dout", int'(dout), 1);

    // randomized traffic against the model
    drive(1, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 4000; n++) begin
      bit r, s, w, st;
      int a;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 4) != 0);
      st = ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 9) < 7) ? key_seq[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
      drive(r, s, w, st, a);
      check("rand_armed", int'(armed), int'(m_armed));
      check("rand_dout", int'(dout), m_dout());
      check("rand_oe", int'(dout_oe), int'(m_armed & sel & rd));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
